// File: rtl/fifo_pkg.sv
// Shared types, mode constants and width helpers for the programmable FIFO.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_err_t;

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a full FIFO (count == depth) is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one write port, one asynchronous read port, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = fifo_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_prog.sv
// Single-clock FIFO with standard/FWFT read modes, programmable almost flags,
// exact occupancy count and sticky overflow/underflow flags.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fifo_init,
    input  logic                        fifo_wr_en,
    input  logic [DATA_W-1:0]           fifo_wr_data,
    input  logic                        fifo_rd_en,
    output logic [DATA_W-1:0]           fifo_rdata,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic                        fifo_afull,
    output logic                        fifo_aempty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_ovf,
    output logic                        fifo_udf
);

    localparam int ADDR_W = fifo_addr_w(FIFO_DEPTH);
    localparam int CNT_W  = fifo_cnt_w(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    if (!fifo_is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 4) begin : g_chk_depth
        $error("fifo_prog: FIFO_DEPTH must be a power of two and >= 4");
    end
    if (AFULL_TH < 1 || AFULL_TH > FIFO_DEPTH) begin : g_chk_afull
        $error("fifo_prog: AFULL_TH out of range 1..FIFO_DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > FIFO_DEPTH - 1) begin : g_chk_aempty
        $error("fifo_prog: AEMPTY_TH out of range 0..FIFO_DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_chk_mode
        $error("fifo_prog: FWFT must be 0 or 1");
    end

    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              afull_q, afull_d, aempty_q, aempty_d;
    fifo_err_t         err_q, err_d;
    logic              wr_acc, rd_acc, flush;
    logic [DATA_W-1:0] ram_rdata;

    assign flush = !rst_n || fifo_init;

    // Accepts use the registered flags, so a full FIFO refuses a write even
    // when a read is accepted on the same edge.
    always_comb begin
        wr_acc    = fifo_wr_en && !full_q  && !flush;
        rd_acc    = fifo_rd_en && !empty_q && !flush;
        wr_ptr_d  = wr_ptr_q + CNT_W'(wr_acc);
        rd_ptr_d  = rd_ptr_q + CNT_W'(rd_acc);
        count_d   = wr_ptr_d - rd_ptr_d;
        full_d    = (count_d == DEPTH_C);
        empty_d   = (count_d == '0);
        afull_d   = (count_d >= AFULL_C);
        aempty_d  = (count_d <= AEMPTY_C);
        err_d.ovf = err_q.ovf | (fifo_wr_en & full_q);
        err_d.udf = err_q.udf | (fifo_rd_en & empty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || fifo_init) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            err_q    <= err_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (fifo_wr_data),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    if (FWFT == FIFO_MODE_STD) begin : g_std
        logic [DATA_W-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (!rst_n || fifo_init) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= ram_rdata;
            end
        end

        assign fifo_rdata = rdata_q;
    end else begin : g_fwft
        assign fifo_rdata = empty_q ? '0 : ram_rdata;
    end

    assign fifo_full   = full_q;
    assign fifo_empty  = empty_q;
    assign fifo_afull  = afull_q;
    assign fifo_aempty = aempty_q;
    assign fifo_count  = count_q;
    assign fifo_ovf    = err_q.ovf;
    assign fifo_udf    = err_q.udf;

endmodule
